// File: rtl/uart_tx_fsm.sv
// UART transmit engine: one byte per valid/ready handshake, sent LSB first
// as start, data, optional parity and stop bits, timed by the shared oversampling tick.
module uart_tx_fsm #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sampling,
  input  logic                 i_tx_valid,
  input  logic [DATA_BITS-1:0] i_tx_d,
  output logic                 o_tx_ready,
  output logic                 o_tx_d,
  output logic                 o_tx_busy,
  output logic                 o_tx_complete
);

  localparam int TW = $clog2(OVERSAMPLE * 2);
  localparam logic [TW-1:0] BIT_END  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_END = TW'(STOP_BITS * OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_COMPLETE
  } state_e;

  state_e               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 hs;
  logic                 tick_inc;
  logic                 bit_end;
  logic                 stop_end;

  assign o_tx_ready    = (state_q == S_IDLE);
  assign o_tx_busy     = (state_q != S_IDLE);
  assign o_tx_complete = (state_q == S_COMPLETE);
  assign o_tx_d        = tx_q;

  assign hs       = i_tx_valid & o_tx_ready;
  assign tick_inc = sampling & o_tx_busy;
  assign bit_end  = sampling & (tick_q == BIT_END);
  assign stop_end = sampling & (tick_q == STOP_END);

  // Next-state, tick/bit counters and next line level (line is registered).
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    if (tick_inc) begin
      tick_d = tick_q + TW'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (hs) begin
          shift_d = i_tx_d;
          par_d   = (^i_tx_d) ^ PARITY_ODD;
          tick_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          tick_d  = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          tick_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 4'd1;
          tx_d    = shift_d[0];
          if (bit_q == LAST_BIT) begin
            if (PARITY_EN) begin
              tx_d    = par_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          tick_d  = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (stop_end) begin
          tick_d  = '0;
          tx_d    = 1'b1;
          state_d = S_COMPLETE;
        end
      end
      S_COMPLETE: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame with the line high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Scoreboard bench for uart_tx_fsm: three configurations, frames predicted
// from data and frame format, line checked against sampling-tick position.
module tb_uart_tx_fsm;

  localparam int ND = 3;
  localparam int OSV [ND] = '{16, 4, 2};
  localparam int DBV [ND] = '{8, 7, 5};
  localparam int PEV [ND] = '{0, 1, 1};
  localparam int POV [ND] = '{0, 0, 1};
  localparam int SBV [ND] = '{1, 2, 1};

  logic clk = 1'b0;
  logic rst_n;
  logic sampling;
  logic samp_en;
  logic [ND-1:0] vld;
  logic [ND-1:0] rdy;
  logic [ND-1:0] line;
  logic [ND-1:0] busy;
  logic [ND-1:0] cmpl;
  logic [7:0] din [ND];
  logic [15:0] expq [ND][$];
  int sent [ND];
  int ccnt [ND];
  int checks;
  int errors;

  always #5 clk = ~clk;

  uart_tx_fsm #(
    .OVERSAMPLE(16), .DATA_BITS(8), .PARITY_EN(1'b0),
    .PARITY_ODD(1'b0), .STOP_BITS(1)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .sampling(sampling),
    .i_tx_valid(vld[0]), .i_tx_d(din[0][7:0]),
    .o_tx_ready(rdy[0]), .o_tx_d(line[0]),
    .o_tx_busy(busy[0]), .o_tx_complete(cmpl[0])
  );

  uart_tx_fsm #(
    .OVERSAMPLE(4), .DATA_BITS(7), .PARITY_EN(1'b1),
    .PARITY_ODD(1'b0), .STOP_BITS(2)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .sampling(sampling),
    .i_tx_valid(vld[1]), .i_tx_d(din[1][6:0]),
    .o_tx_ready(rdy[1]), .o_tx_d(line[1]),
    .o_tx_busy(busy[1]), .o_tx_complete(cmpl[1])
  );

  uart_tx_fsm #(
    .OVERSAMPLE(2), .DATA_BITS(5), .PARITY_EN(1'b1),
    .PARITY_ODD(1'b1), .STOP_BITS(1)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .sampling(sampling),
    .i_tx_valid(vld[2]), .i_tx_d(din[2][4:0]),
    .o_tx_ready(rdy[2]), .o_tx_d(line[2]),
    .o_tx_busy(busy[2]), .o_tx_complete(cmpl[2])
  );

  // Expected line levels of a frame, bit 0 = start bit, unused tail = 1.
  function automatic logic [15:0] model(int g, logic [7:0] data);
    logic [15:0] f;
    int ones;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < DBV[g]; i++) begin
      f[1+i] = data[i];
      ones += int'(data[i]);
    end
    if (PEV[g] != 0) begin
      if (POV[g] != 0) f[1+DBV[g]] = (ones % 2 == 0);
      else             f[1+DBV[g]] = (ones % 2 == 1);
    end
    return f;
  endfunction

  // Shared oversampling tick: one pulse every 4 clocks while enabled.
  initial begin
    int ph;
    ph = 0;
    sampling = 1'b0;
    forever begin
      @(negedge clk);
      sampling = samp_en && (ph == 0);
      ph = (ph + 1) % 4;
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < ND; g++)
      if (rst_n === 1'b1 && cmpl[g] === 1'b1) ccnt[g]++;
  end

  for (genvar g = 0; g < ND; g++) begin : mon
    localparam int OS = OSV[g];
    localparam int NB = 1 + DBV[g] + PEV[g] + SBV[g];
    logic [15:0] ef;
    logic got;
    bit act, tail, bad, fbad, s;
    int c, bi;

    task automatic fin_bit();
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL dut%0d bit%0d line: got %b want %b",
                 g, bi, got, ef[bi]);
      end
    endtask

    initial begin
      act = 0;
      tail = 0;
      forever begin
        @(posedge clk);
        s = sampling;
        #1;
        if (rst_n !== 1'b1) begin
          act = 0;
          tail = 0;
        end else if (act && tail) begin
          checks++;
          if (busy[g] !== 1'b0 || rdy[g] !== 1'b1 || cmpl[g] !== 1'b0 ||
              line[g] !== 1'b1 || fbad) begin
            errors++;
            $display("FAIL dut%0d frame flags: busy=%b rdy=%b cmpl=%b flagerr=%0d want 0 1 0 0",
                     g, busy[g], rdy[g], cmpl[g], fbad);
          end
          act = 0;
          tail = 0;
        end else begin
          if (act && s) c++;
          if (!act && busy[g] === 1'b1) begin
            act = 1;
            c = 0;
            bi = 0;
            bad = 0;
            fbad = 0;
            if (expq[g].size() > 0) begin
              ef = expq[g].pop_front();
            end else begin
              ef = '1;
              checks++;
              errors++;
              $display("FAIL dut%0d start: got busy=1 want idle (no frame queued)", g);
            end
          end
          if (act) begin
            if (c < NB * OS) begin
              if (c / OS != bi) begin
                fin_bit();
                bi = c / OS;
                bad = 0;
              end
              if (!bad && line[g] !== ef[bi]) begin
                bad = 1;
                got = line[g];
              end
              if (busy[g] !== 1'b1 || rdy[g] !== 1'b0 || cmpl[g] !== 1'b0)
                fbad = 1;
            end else begin
              fin_bit();
              checks++;
              if (cmpl[g] !== 1'b1 || line[g] !== 1'b1 || busy[g] !== 1'b1) begin
                errors++;
                $display("FAIL dut%0d complete: cmpl=%b line=%b busy=%b want 1 1 1",
                         g, cmpl[g], line[g], busy[g]);
              end
              tail = 1;
            end
          end
        end
      end
    end
  end

  task automatic send(input int g, input logic [7:0] data, input bit hold);
    int n;
    @(negedge clk);
    vld[g] = 1'b1;
    din[g] = data;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (rdy[g] !== 1'b1 && n < 3000);
    if (rdy[g] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL dut%0d handshake: rdy=%b want 1 within 3000 clk", g, rdy[g]);
    end else begin
      expq[g].push_back(model(g, data));
      sent[g]++;
    end
    @(negedge clk);
    din[g] = 8'($urandom);
    if (!hold) vld[g] = 1'b0;
  endtask

  task automatic wait_done(input int g);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy[g] !== 1'b0 || rdy[g] !== 1'b1) && n < 3000);
    if (busy[g] !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d done: busy=%b want 0 within 3000 clk", g, busy[g]);
    end
  endtask

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: got no finish want finish before 90000 clk");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic lb;
    int g;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    samp_en = 1'b1;
    vld = '0;
    for (int i = 0; i < ND; i++) din[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (line[i] !== 1'b1 || busy[i] !== 1'b0 || cmpl[i] !== 1'b0 || rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL dut%0d reset: line=%b busy=%b cmpl=%b rdy=%b want 1 0 0 1",
                 i, line[i], busy[i], cmpl[i], rdy[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send(0, 8'h55, 0);
    wait_done(0);
    send(1, 8'h07, 0);
    wait_done(1);
    send(2, 8'h00, 0);
    wait_done(2);
    send(1, 8'hA3, 0);
    wait_done(1);
    send(0, 8'h01, 1);
    send(0, 8'hFE, 0);
    wait_done(0);

    send(0, 8'($urandom), 0);
    repeat (285) @(negedge clk);
    #2;
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL dut0 prereset busy: got %b want 1", busy[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (line[0] !== 1'b1 || busy[0] !== 1'b0 || cmpl[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL dut0 async reset: line=%b busy=%b cmpl=%b rdy=%b want 1 0 0 1",
               line[0], busy[0], cmpl[0], rdy[0]);
    end
    sent[0]--;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 8'h3C, 0);
    wait_done(0);

    send(0, 8'($urandom), 0);
    repeat (200) @(negedge clk);
    #1;
    samp_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    lb = line[0];
    repeat (100) @(negedge clk);
    #1;
    checks++;
    if (line[0] !== lb || busy[0] !== 1'b1 || rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL dut0 freeze: line=%b busy=%b rdy=%b want %b 1 0",
               line[0], busy[0], rdy[0], lb);
    end
    samp_en = 1'b1;
    wait_done(0);

    for (int k = 0; k < 12; k++) begin
      g = $urandom_range(0, ND - 1);
      send(g, 8'($urandom), 1'($urandom));
      send(g, 8'($urandom), 0);
      wait_done(g);
    end

    repeat (10) @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (expq[i].size() != 0) begin
        errors++;
        $display("FAIL dut%0d pending frames: got %0d want 0", i, expq[i].size());
      end
      checks++;
      if (ccnt[i] != sent[i]) begin
        errors++;
        $display("FAIL dut%0d complete count: got %0d want %0d", i, ccnt[i], sent[i]);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
